ssd_scan_ctrl: RTL and testbench
================================

// Module: ssd_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for the 4-digit seven-segment display.
//   Holds a tear-free shadow copy of four 4-bit display codes, steps one digit at a time, and drives the active-low anodes.
//   Feeds each code through one bcd_to_ssd decoder instance; codes 10-13 show as letters L/E/V/N, 14-15 show as blank.
//   Sits between the game/score logic and the board's SSD pins.
// PARAMETERS
//   SCAN_DIV   100000  clk cycles per digit slot (BLANK + SHOW); must be > BLANK_CYC+1
//   BLANK_CYC  8       anti-ghost cycles per slot with all anodes off
//   BLINK_DIV  64      frames per blink half-period (SSD_BLINK_EN only)
// PORTS
//   clk         in   1   system clock
//   rst         in   1   asynchronous, active-high reset
//   en          in   1   1 = scan; 0 = display dark
//   load        in   1   1-cycle strobe: capture digits_in/dp_in
//   digits_in   in   16  [15:12] = leftmost digit ... [3:0] = rightmost digit
//   dp_in       in   4   decimal point per digit, 1 = lit
//   lz_en       in   1   leading-zero suppression enable
//   blink_mask  in   4   per-digit blink enable (SSD_BLINK_EN only)
//   ssd_ctl     out  4   anodes, active-low; bit3 = leftmost digit
//   ssd_out     out  8   segments a..g in [7:1], dp in [0], all active-low
//   frame_done  out  1   1-cycle pulse after the digit-0 slot ends
// BEHAVIOUR
//   Clock/reset: one clock clk; reset rst is asynchronous and active-high.
//   Reset (async, takes effect immediately, also mid-frame): FSM=IDLE, ssd_ctl=4'hF, ssd_out=8'hFF, frame_done=0.
//     Reset also sets shadow/pending codes to 4'hF, dp to 0, pending flag to 0, slot counter to 0, and digit index to 3.
//   FSM states:
//     IDLE: dark.
//       en=1 -> BLANK, digit index=3, counter=0.
//     BLANK: all anodes off for BLANK_CYC cycles, then -> SHOW.
//     SHOW: anode[idx] low for SCAN_DIV-BLANK_CYC cycles.
//       At the end of the slot: idx--; if the old idx was 0, wrap to 3 and fire frame_done; then -> BLANK.
//     Any state with en=0 -> IDLE on the next edge; counter and idx are cleared.
//   Outputs are registered: ssd_ctl/ssd_out change 1 cycle after the FSM state/idx change.
//   Load (double buffer):
//     load captures into the pending regs and sets the pending flag.
//     Pending contents copy to the shadow regs only at a frame boundary (the frame_done cycle) or while in IDLE.
//     load on the boundary cycle itself: the new value goes straight to shadow.
//     Back-to-back loads: the last one wins.
//   Leading-zero suppression (lz_en=1):
//     Digit k in 3..1 is blanked if its code is 0 and all higher digits are 0 or blanked.
//     Digit 0 is never suppressed. Codes 1-13 count as non-zero. The dp of a suppressed digit is still shown.
//   Segment path: code -> bcd_to_ssd -> seg; ssd_out = {seg[7:1], ~dp[idx]}. Blank = code 4'hF.
//   Refresh period = 4*SCAN_DIV cycles (4 ms at 100 MHz with defaults).
// CONFIGURATION
//   Macro SSD_BLINK_EN:
//     Defined:
//       - adds the blink_mask port and a frame counter/phase bit; the phase toggles every BLINK_DIV frame_done pulses.
//       - during the off phase, digits with blink_mask[k]=1 show 8'hFF (dp also off).
//       - reset sets phase = on.
//     Undefined: no blink_mask port, no counter; behaviour is identical to blink_mask=0.
// STRUCTURE
//   Shared package/header ssd_pkg:
//     - SSD state encodings (IDLE/BLANK/SHOW).
//     - BCD_BLANK=4'hF.
//     - SSD_OFF=8'hFF.
//     - BCD_BIT_WIDTH, SSD_BIT_WIDTH, and the digit count 4.
//   Sub-module: one bcd_to_ssd instance (combinational decoder), muxed by idx; no other hierarchy.
// TESTING (bench: SCAN_DIV=16, BLANK_CYC=2, BLINK_DIV=2)
//   1. load 16'h1234, en=1 -> per slot: ssd_ctl 4'hF for 2 cycles, then 4'b0111 with ssd_out=8'h9F ('1') for 14 cycles.
//      Following slots show 1011/'2' (8'h25), 1101/'3', 1110/'4'; frame_done pulses every 64 cycles.
//   2. Mid-frame load 16'h5678 while digit 2 shows -> digits 1,0 still show '3','4'.
//      From the next frame: '5','6','7','8'. Load on the frame_done cycle shows the new value in the immediately following frame.
//   3. lz_en=1, digits 16'h0040 -> digit3 and digit2 show 8'hFF, digit1 '4', digit0 '0' (8'h03).
//      Digits 16'h0000 -> only digit0 shows '0'. Digits 16'hA0B0 -> nothing suppressed (L,0,E,0).
//   4. dp_in=4'b0010 with 16'h0008 -> digit1 ssd_out = 8'h02 (segments '0', dp lit); other digits have bit0=1.
//   5. Assert rst mid-SHOW -> same cycle: ssd_ctl=4'hF, ssd_out=8'hFF.
//      After release with en=1: scan restarts at digit3 with blank codes, until the next load.
//   6. en drop mid-slot -> next cycle the FSM is IDLE, 1 cycle later the outputs are dark.
//      SSD_BLINK_EN, blink_mask=4'b0001 -> digit0 dark in alternating pairs of frames.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared encodings, widths and constants for the seven-segment scan controller.
package ssd_pkg;
    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} ssd_state_e;
    localparam int BCD_BIT_WIDTH = 4;
    localparam int SSD_BIT_WIDTH = 8;
    localparam int NUM_DIGITS = 4;
    localparam logic [BCD_BIT_WIDTH-1:0] BCD_BLANK = 4'hF;
    localparam logic [SSD_BIT_WIDTH-1:0] SSD_OFF = 8'hFF;
    // codes 14/15 render blank, so they do not end a run of leading zeros
    function automatic logic lead_zero_ok(input logic [BCD_BIT_WIDTH-1:0] c);
        return c == 4'd0 || c >= 4'd14;
    endfunction
endpackage

// File: rtl/bcd_to_ssd.sv
// bcd_to_ssd: active-low a..g decoder; 0-9 digits, 10-13 letters L/E/V/N, 14-15 blank.
module bcd_to_ssd
    import ssd_pkg::*;
(
    input  logic [BCD_BIT_WIDTH-1:0] bcd,
    output logic [SSD_BIT_WIDTH-1:1] seg
);
    always_comb begin
        seg = 7'b1111111;
        case (bcd)
            4'd0:  seg = 7'b0000001;
            4'd1:  seg = 7'b1001111;
            4'd2:  seg = 7'b0010010;
            4'd3:  seg = 7'b0000110;
            4'd4:  seg = 7'b1001100;
            4'd5:  seg = 7'b0100100;
            4'd6:  seg = 7'b0100000;
            4'd7:  seg = 7'b0001111;
            4'd8:  seg = 7'b0000000;
            4'd9:  seg = 7'b0000100;
            4'd10: seg = 7'b1110001;
            4'd11: seg = 7'b0110000;
            4'd12: seg = 7'b1000001;
            4'd13: seg = 7'b0001001;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: double-buffered 4-digit seven-segment scan controller with anti-ghost blanking.
// Define SSD_BLINK_EN to add the blink_mask port and per-digit frame-rate blinking.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 8,
    parameter int BLINK_DIV = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                load,
    input  logic [NUM_DIGITS*BCD_BIT_WIDTH-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]               dp_in,
    input  logic                                lz_en,
`ifdef SSD_BLINK_EN
    input  logic [NUM_DIGITS-1:0]               blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]               ssd_ctl,
    output logic [SSD_BIT_WIDTH-1:0]            ssd_out,
    output logic                                frame_done
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = NUM_DIGITS*BCD_BIT_WIDTH;

    ssd_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic [DW-1:0] shadow_q, shadow_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0] sdp_q, sdp_d, pdp_q, pdp_d, ctl_q, ctl_d, sup;
    logic pflag_q, pflag_d, fd_q, fd_d, swap, blk;
    logic [SSD_BIT_WIDTH-1:0] out_q, out_d;
    logic [BCD_BIT_WIDTH-1:0] code;
    logic [SSD_BIT_WIDTH-1:1] seg;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        fd_d = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d = '0;
            idx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d = '0;
                    idx_d = 2'd3;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    state_d = cnt_q == CW'(BLANK_CYC-1) ? S_SHOW : S_BLANK;
                end
                S_SHOW: begin
                    if (cnt_q == CW'(SCAN_DIV-1)) begin
                        state_d = S_BLANK;
                        cnt_d = '0;
                        idx_d = idx_q - 1'b1;
                        fd_d = idx_q == 2'd0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // pending copy lands in shadow only between frames, so a frame never mixes old and new digits
    always_comb begin
        swap = fd_q || state_q == S_IDLE;
        pend_d = load ? digits_in : pend_q;
        pdp_d = load ? dp_in : pdp_q;
        pflag_d = load ? !swap : pflag_q && !swap;
        shadow_d = !swap ? shadow_q : load ? digits_in : pflag_q ? pend_q : shadow_q;
        sdp_d = !swap ? sdp_q : load ? dp_in : pflag_q ? pdp_q : sdp_q;
    end

    always_comb begin
        sup[3] = lz_en && shadow_q[15:12] == 4'd0;
        sup[2] = lz_en && shadow_q[11:8] == 4'd0 && lead_zero_ok(shadow_q[15:12]);
        sup[1] = lz_en && shadow_q[7:4] == 4'd0 && lead_zero_ok(shadow_q[15:12]) && lead_zero_ok(shadow_q[11:8]);
        sup[0] = 1'b0;
        code = sup[idx_q] ? BCD_BLANK : shadow_q[{idx_q, 2'b00} +: BCD_BIT_WIDTH];
    end

    bcd_to_ssd u_dec (.bcd(code), .seg(seg));

`ifdef SSD_BLINK_EN
    localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic phase_q, phase_d;
    always_comb begin
        fcnt_d = fd_q ? (fcnt_q == FW'(BLINK_DIV-1) ? '0 : fcnt_q + 1'b1) : fcnt_q;
        phase_d = phase_q ^ (fd_q && fcnt_q == FW'(BLINK_DIV-1));
        blk = !phase_q && blink_mask[idx_q];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q <= '0;
            phase_q <= 1'b1;
        end else begin
            fcnt_q <= fcnt_d;
            phase_q <= phase_d;
        end
    end
`else
    assign blk = 1'b0;
`endif

    always_comb begin
        ctl_d = state_q == S_SHOW ? ~(4'b0001 << idx_q) : 4'hF;
        out_d = (state_q == S_SHOW && !blk) ? {seg, ~sdp_q[idx_q]} : SSD_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            idx_q <= 2'd3;
            shadow_q <= {NUM_DIGITS{BCD_BLANK}};
            pend_q <= {NUM_DIGITS{BCD_BLANK}};
            sdp_q <= '0;
            pdp_q <= '0;
            pflag_q <= 1'b0;
            ctl_q <= 4'hF;
            out_q <= SSD_OFF;
            fd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            shadow_q <= shadow_d;
            pend_q <= pend_d;
            sdp_q <= sdp_d;
            pdp_q <= pdp_d;
            pflag_q <= pflag_d;
            ctl_q <= ctl_d;
            out_q <= out_d;
            fd_q <= fd_d;
        end
    end

    assign ssd_ctl = ctl_q;
    assign ssd_out = out_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed stimulus with a frame-position model checked every cycle.
module tb_ssd_scan_ctrl;
    localparam int SD = 16;
    localparam int BC = 2;
    localparam int BD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic load = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0] dp_in = 4'h0;
    logic lz_en = 1'b0;
`ifdef SSD_BLINK_EN
    logic [3:0] blink_mask = 4'h0;
`endif
    logic [3:0] ssd_ctl;
    logic [7:0] ssd_out;
    logic frame_done;

    int checks = 0;
    int errors = 0;
    bit go = 1'b0;

    ssd_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .lz_en(lz_en),
`ifdef SSD_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .ssd_ctl(ssd_ctl), .ssd_out(ssd_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // model: segment patterns (a..g, active low) straight from the character shapes
    logic [6:0] dec [16];
    int ph;
    logic [3:0] md [4];
    logic [3:0] pd [4];
    logic [3:0] mdp, pdp;
    bit pfl, e_fd;
    logic [3:0] e_ctl;
    logic [7:0] e_out;
    int nfd;

    task automatic mreset();
        ph = -1;
        for (int k = 0; k < 4; k++) begin
            md[k] = 4'hF;
            pd[k] = 4'hF;
        end
        mdp = 4'h0;
        pdp = 4'h0;
        pfl = 1'b0;
        e_fd = 1'b0;
        e_ctl = 4'hF;
        e_out = 8'hFF;
        nfd = 0;
    endtask

    function automatic logic [3:0] shown(input int dg);
        bit lead = lz_en;
        for (int k = 3; k > dg; k--)
            if (md[k] >= 4'd1 && md[k] <= 4'd13) lead = 1'b0;
        return (lead && dg != 0 && md[dg] == 4'd0) ? 4'hF : md[dg];
    endfunction

    task automatic mstep();
        logic [3:0] nc;
        logic [7:0] no;
        bit nf, swap, on, blk;
        int dg;
        nc = 4'hF;
        no = 8'hFF;
        on = ((nfd / BD) % 2) == 0;
        if (ph >= 0 && ph % SD >= BC) begin
            dg = 3 - (ph / SD) % 4;
            nc = ~(4'b0001 << dg);
            blk = 1'b0;
`ifdef SSD_BLINK_EN
            blk = !on && blink_mask[dg];
`endif
            no = blk ? 8'hFF : {dec[shown(dg)], ~mdp[dg]};
        end
        nf = en && ph >= 0 && ph % (4*SD) == 4*SD - 1;
        swap = e_fd || ph < 0;
        if (load && swap) begin
            for (int k = 0; k < 4; k++) md[k] = digits_in[4*k +: 4];
            mdp = dp_in;
            pfl = 1'b0;
        end else if (load) begin
            for (int k = 0; k < 4; k++) pd[k] = digits_in[4*k +: 4];
            pdp = dp_in;
            pfl = 1'b1;
        end else if (swap && pfl) begin
            for (int k = 0; k < 4; k++) md[k] = pd[k];
            mdp = pdp;
            pfl = 1'b0;
        end
        if (e_fd) nfd++;
        ph = en ? ph + 1 : -1;
        e_ctl = nc;
        e_out = no;
        e_fd = nf;
    endtask

    initial begin
        dec[0] = 7'b0000001; dec[1] = 7'b1001111; dec[2] = 7'b0010010; dec[3] = 7'b0000110;
        dec[4] = 7'b1001100; dec[5] = 7'b0100100; dec[6] = 7'b0100000; dec[7] = 7'b0001111;
        dec[8] = 7'b0000000; dec[9] = 7'b0000100; dec[10] = 7'b1110001; dec[11] = 7'b0110000;
        dec[12] = 7'b1000001; dec[13] = 7'b0001001; dec[14] = 7'b1111111; dec[15] = 7'b1111111;
        mreset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) mreset();
            else mstep();
        end
    end

    always @(negedge clk) begin
        if (!rst && go) begin
            chk("model_ctl", {4'h0, ssd_ctl}, {4'h0, e_ctl});
            chk("model_out", ssd_out, e_out);
            chk("model_fd", {7'h0, frame_done}, {7'h0, e_fd});
        end
    end

    task automatic show(input string nm, input logic [3:0] c, input logic [7:0] o, input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ssd_ctl !== c && n < lim);
        if (ssd_ctl !== c) begin
            checks++;
            errors++;
            $display("FAIL %s_wait ssd_ctl actual=%h expected=%h", nm, ssd_ctl, c);
        end
        chk(nm, ssd_out, o);
    endtask

    task automatic wait_fd(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < lim);
        if (frame_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_done_wait actual=0 expected=1");
        end
    endtask

    task automatic do_load(input logic [15:0] d);
        digits_in = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {4'h0, ssd_ctl}, 8'h0F);
        chk("rst_out", ssd_out, 8'hFF);
        chk("rst_fd", {7'h0, frame_done}, 8'h00);
        #1 rst = 1'b0;
        go = 1'b1;
        @(negedge clk);
        // 1: basic scan
        do_load(16'h1234);
        en = 1'b1;
        show("t1_d3", 4'b0111, 8'h9F, 40);
        show("t1_d2", 4'b1011, 8'h25, 40);
        show("t1_d1", 4'b1101, 8'h0D, 40);
        show("t1_d0", 4'b1110, 8'h99, 40);
        wait_fd(100, n);
        wait_fd(100, n);
        chk("frame_period", 8'(n), 8'd64);
        // 2: mid-frame load waits for the frame boundary
        show("t2_d2_old", 4'b1011, 8'h25, 80);
        do_load(16'h5678);
        show("t2_d1_old", 4'b1101, 8'h0D, 40);
        show("t2_d0_old", 4'b1110, 8'h99, 40);
        show("t2_d3_new", 4'b0111, 8'h49, 40);
        show("t2_d2_new", 4'b1011, 8'h41, 40);
        show("t2_d1_new", 4'b1101, 8'h1F, 40);
        show("t2_d0_new", 4'b1110, 8'h01, 40);
        wait_fd(100, n);
        do_load(16'h1234);
        show("t2_fd_load", 4'b0111, 8'h9F, 20);
        // 3: leading-zero suppression
        lz_en = 1'b1;
        do_load(16'h0040);
        wait_fd(100, n);
        show("t3a_d3", 4'b0111, 8'hFF, 40);
        show("t3a_d2", 4'b1011, 8'hFF, 40);
        show("t3a_d1", 4'b1101, 8'h99, 40);
        show("t3a_d0", 4'b1110, 8'h03, 40);
        do_load(16'h0000);
        wait_fd(100, n);
        show("t3b_d3", 4'b0111, 8'hFF, 40);
        show("t3b_d2", 4'b1011, 8'hFF, 40);
        show("t3b_d1", 4'b1101, 8'hFF, 40);
        show("t3b_d0", 4'b1110, 8'h03, 40);
        do_load(16'hA0B0);
        wait_fd(100, n);
        show("t3c_d3", 4'b0111, 8'hE3, 40);
        show("t3c_d2", 4'b1011, 8'h03, 40);
        show("t3c_d1", 4'b1101, 8'h61, 40);
        show("t3c_d0", 4'b1110, 8'h03, 40);
        // 4: decimal point
        lz_en = 1'b0;
        dp_in = 4'b0010;
        do_load(16'h0008);
        dp_in = 4'b0000;
        wait_fd(100, n);
        show("t4_d3", 4'b0111, 8'h03, 40);
        show("t4_d2", 4'b1011, 8'h03, 40);
        show("t4_d1", 4'b1101, 8'h02, 40);
        show("t4_d0", 4'b1110, 8'h01, 40);
        // 6: enable drop
        show("t6_d2", 4'b1011, 8'h03, 80);
        en = 1'b0;
        @(negedge clk);
        chk("t6_ctl_lag", {4'h0, ssd_ctl}, 8'h0B);
        @(negedge clk);
        chk("t6_ctl_dark", {4'h0, ssd_ctl}, 8'h0F);
        chk("t6_out_dark", ssd_out, 8'hFF);
        repeat (3) @(negedge clk);
        en = 1'b1;
        // 5: asynchronous reset mid-SHOW
        show("t5_d1", 4'b1101, 8'h02, 80);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_ctl", {4'h0, ssd_ctl}, 8'h0F);
        chk("t5_rst_out", ssd_out, 8'hFF);
        chk("t5_rst_fd", {7'h0, frame_done}, 8'h00);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        show("t5_blank_d3", 4'b0111, 8'hFF, 40);
        show("t5_blank_d0", 4'b1110, 8'hFF, 80);
        // blink (mask only exists with SSD_BLINK_EN)
`ifdef SSD_BLINK_EN
        blink_mask = 4'b0001;
`endif
        do_load(16'h1234);
        repeat (8 * 4 * SD) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
